clause_array_ctrl: RTL

CLAUSE_ARRAY_CTRL -- requirements
Module: clause_array_ctrl

---
 rtl/sat_ctrl_pkg.sv | 28 ++
 rtl/clause_array_ctrl_if.sv | 45 ++++
 rtl/clause_array_ctrl_phase_timer.sv | 30 +++
 rtl/clause_array_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sat_ctrl_pkg.sv
// Shared types for the clause-array controller: FSM state encoding and
// array phase constants, plus the saturating statistics increment.
package sat_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_IMP,
    ST_EVAL,
    ST_CCL,
    ST_BKT,
    ST_DONE
  } state_e;

  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_NONE = 3'b000;
  localparam phase_t PHASE_IMP  = 3'b001;
  localparam phase_t PHASE_CCL  = 3'b010;
  localparam phase_t PHASE_BKT  = 3'b100;

  localparam int unsigned TIMER_W = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/clause_array_ctrl_if.sv
// Bundle of host start/status, clause-source handshake and array-side
// signals of clause_array_ctrl; slave is the controller, master its environment.
interface clause_array_ctrl_if #(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_LITS    = 8,
  parameter int unsigned WIDTH_LVL   = 16
);
  localparam int unsigned NUM_W = $clog2(NUM_CLAUSES) + 1;

  logic                   load_start_i;
  logic [NUM_W-1:0]       load_num_i;
  logic                   clause_valid_i;
  logic                   clause_ready_o;
  logic [NUM_LITS*2-1:0]  clause_lits_i;
  logic [NUM_CLAUSES-1:0] wr_o;
  logic [NUM_LITS*2-1:0]  lit_o;
  logic                   bcp_start_i;
  logic                   bkt_start_i;
  logic                   imp_drv_o;
  logic                   cclause_drv_o;
  logic                   apply_bkt_o;
  logic [NUM_CLAUSES-1:0] cclause_i;
  logic [NUM_CLAUSES-1:0] clausesat_i;
  logic [WIDTH_LVL-1:0]   max_lvl_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   conflict_o;
  logic                   all_sat_o;
  logic [WIDTH_LVL-1:0]   conflict_lvl_o;

  modport master (
    output load_start_i, load_num_i, clause_valid_i, clause_lits_i,
           bcp_start_i, bkt_start_i, cclause_i, clausesat_i, max_lvl_i,
    input  clause_ready_o, wr_o, lit_o, imp_drv_o, cclause_drv_o, apply_bkt_o,
           busy_o, done_o, conflict_o, all_sat_o, conflict_lvl_o
  );

  modport slave (
    input  load_start_i, load_num_i, clause_valid_i, clause_lits_i,
           bcp_start_i, bkt_start_i, cclause_i, clausesat_i, max_lvl_i,
    output clause_ready_o, wr_o, lit_o, imp_drv_o, cclause_drv_o, apply_bkt_o,
           busy_o, done_o, conflict_o, all_sat_o, conflict_lvl_o
  );

endinterface

// File: rtl/clause_array_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that pulses expire on the last
// cycle of a window while run is held.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  always_comb begin
    expire = run && (count == WIDTH'(1));
  end

endmodule

// File: rtl/clause_array_ctrl.sv
// Clause-array controller: loads clause rows, sequences propagation and
// backtrack phases. Optional conflict counter: CLAUSE_ARRAY_CTRL_STAT_EN.
module clause_array_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_LITS    = 8,
  parameter int unsigned WIDTH_LVL   = 16,
  parameter int unsigned IMP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CLAUSE_ARRAY_CTRL_STAT_EN
  output logic [15:0] conflict_cnt_o,
`endif
  clause_array_ctrl_if.slave bus
);

  localparam int unsigned NUM_W = $clog2(NUM_CLAUSES) + 1;
  localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(NUM_CLAUSES);

  state_e               state, state_nxt;
  phase_t               phase;
  logic [NUM_W-1:0]     ptr, num, num_sat;
  logic                 load_acc, ptr_inc;
  logic                 flags_clr, set_conflict, set_all_sat;
  logic                 timer_ld, timer_exp;
  logic                 conflict, all_sat;
  logic [WIDTH_LVL-1:0] conflict_lvl;

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_ld),
    .load_val (TIMER_W'(IMP_CYCLES)),
    .run      (state == ST_IMP),
    .expire   (timer_exp)
  );

  always_comb begin
    num_sat = (bus.load_num_i > MAX_NUM) ? MAX_NUM : bus.load_num_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    phase              = PHASE_NONE;
    load_acc           = 1'b0;
    ptr_inc            = 1'b0;
    flags_clr          = 1'b0;
    set_conflict       = 1'b0;
    set_all_sat        = 1'b0;
    timer_ld           = 1'b0;
    bus.clause_ready_o = 1'b0;
    bus.done_o         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Start priority load > bkt > bcp; starts in other states are dropped
        if (bus.load_start_i) begin
          load_acc  = 1'b1;
          state_nxt = (num_sat == '0) ? ST_DONE : ST_LOAD;
        end else if (bus.bkt_start_i) begin
          flags_clr = 1'b1;
          state_nxt = ST_BKT;
        end else if (bus.bcp_start_i) begin
          flags_clr = 1'b1;
          timer_ld  = 1'b1;
          state_nxt = ST_IMP;
        end
      end
      ST_LOAD: begin
        bus.clause_ready_o = 1'b1;
        if (bus.clause_valid_i) begin
          ptr_inc = 1'b1;
          if (ptr == num - 1'b1) state_nxt = ST_DONE;
        end
      end
      ST_IMP: begin
        phase = PHASE_IMP;
        if (timer_exp) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (|bus.cclause_i) begin
          state_nxt = ST_CCL;
        end else begin
          set_all_sat = &bus.clausesat_i;
          state_nxt   = ST_DONE;
        end
      end
      ST_CCL: begin
        phase        = PHASE_CCL;
        set_conflict = 1'b1;
        state_nxt    = ST_DONE;
      end
      ST_BKT: begin
        phase     = PHASE_BKT;
        flags_clr = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_o  = '0;
    bus.lit_o = '0;
    if ((state == ST_LOAD) && bus.clause_valid_i) begin
      bus.wr_o[ptr[NUM_W-2:0]] = 1'b1;
      bus.lit_o                = bus.clause_lits_i;
    end
    bus.busy_o         = (state != ST_IDLE);
    bus.imp_drv_o      = (phase == PHASE_IMP);
    bus.cclause_drv_o  = (phase == PHASE_CCL);
    bus.apply_bkt_o    = (phase == PHASE_BKT);
    bus.conflict_o     = conflict;
    bus.all_sat_o      = all_sat;
    bus.conflict_lvl_o = conflict_lvl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      num          <= '0;
      conflict     <= 1'b0;
      all_sat      <= 1'b0;
      conflict_lvl <= '0;
    end else begin
      if (load_acc) begin
        ptr <= '0;
        num <= num_sat;
      end else if (ptr_inc) begin
        ptr <= ptr + 1'b1;
      end
      if (flags_clr) begin
        conflict     <= 1'b0;
        all_sat      <= 1'b0;
        conflict_lvl <= '0;
      end
      if (set_all_sat) all_sat <= 1'b1;
      if (set_conflict) begin
        conflict     <= 1'b1;
        conflict_lvl <= bus.max_lvl_i;
      end
    end
  end

`ifdef CLAUSE_ARRAY_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_o <= '0;
    end else if (set_conflict) begin
      conflict_cnt_o <= sat_inc16(conflict_cnt_o);
    end
  end
`endif

endmodule
